// File: rtl/useq_pkg.sv
// Shared types and constants for the microsequencer controller and its loop counter.
package useq_pkg;

    localparam int USEQ_ROM_ADDR_W = 8;
    localparam int USEQ_LOOP_W     = 6;
    localparam int USEQ_MAX_UOPS   = 64;
    localparam int USEQ_ROM_ROWS   = 1 << USEQ_ROM_ADDR_W;

    typedef logic [USEQ_ROM_ADDR_W-1:0] t_rom_addr;

    localparam t_rom_addr USEQ_ROM_FIRST = '0;
    localparam t_rom_addr USEQ_ROM_LAST  = '1;

    typedef enum logic {
        USEQ_IDLE  = 1'b0,
        USEQ_FETCH = 1'b1
    } t_useq_fsm;

    typedef struct packed {
        logic                   eom;
        logic                   jmp;
        logic                   loop;
        logic                   ldcnt;
        t_rom_addr              tgt;
        logic [USEQ_LOOP_W-1:0] cnt;
    } t_useq_ctl;

endpackage

// File: rtl/useq_loop_cnt.sv
// Loop counter for ucode flows: cleared on flow entry, loaded by ldcnt rows, decremented by taken loops.
module useq_loop_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Load takes priority over decrement so an ldcnt row always sets a fresh count.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/useq_ctl.sv
// Microsequencer controller: takes decode traps into the ucode ROM and walks the flow one uop per cycle.
module useq_ctl
    import useq_pkg::*;
#(
    parameter int ROM_ADDR_W = USEQ_ROM_ADDR_W,
    parameter int LOOP_W     = USEQ_LOOP_W,
    parameter int MAX_UOPS   = USEQ_MAX_UOPS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  nuke_rb1,
    input  logic                  trap_valid_de1,
    input  logic [ROM_ADDR_W-1:0] trap_addr_de1,
    output logic                  trap_ready_uc0,
    input  logic                  rename_ready_rn0,
    output logic [ROM_ADDR_W-1:0] rom_addr_uc0,
    input  logic                  rom_eom_uc0,
    input  logic                  rom_jmp_uc0,
    input  logic                  rom_loop_uc0,
    input  logic                  rom_ldcnt_uc0,
    input  logic [ROM_ADDR_W-1:0] rom_tgt_uc0,
    input  logic [LOOP_W-1:0]     rom_cnt_uc0,
    output logic                  uop_valid_uc0,
    output logic                  active_uc0,
    output logic                  err_uc0
);

    localparam int NUOPS_W = $clog2(MAX_UOPS) + 1;

    t_useq_fsm             state;
    t_useq_ctl             row;
    logic [ROM_ADDR_W-1:0] pc;
    logic [ROM_ADDR_W-1:0] pc_next;
    logic [NUOPS_W-1:0]    nuops;
    logic                  err;
    logic [LOOP_W-1:0]     cnt;
    logic                  cnt_zero;
    logic                  accept;
    logic                  advance;
    logic                  loop_taken;
    logic                  pc_wrap;
    logic                  watchdog;

    assign row = '{eom:   rom_eom_uc0,
                   jmp:   rom_jmp_uc0,
                   loop:  rom_loop_uc0,
                   ldcnt: rom_ldcnt_uc0,
                   tgt:   t_rom_addr'(rom_tgt_uc0),
                   cnt:   USEQ_LOOP_W'(rom_cnt_uc0)};

    assign trap_ready_uc0 = (state == USEQ_IDLE) && rename_ready_rn0 && !nuke_rb1;
    assign accept         = trap_valid_de1 && trap_ready_uc0;
    assign uop_valid_uc0  = (state == USEQ_FETCH) && !nuke_rb1;
    assign active_uc0     = uop_valid_uc0;
    assign advance        = uop_valid_uc0 && rename_ready_rn0;
    assign rom_addr_uc0   = pc;
    assign err_uc0        = err;

    assign loop_taken = row.loop && !cnt_zero;
    assign watchdog   = (nuops == NUOPS_W'(MAX_UOPS - 1)) && !row.eom;

    // A loop row outranks a jump on the same row, even when it falls through.
    always_comb begin
        pc_wrap = 1'b0;
        if (loop_taken || (row.jmp && !row.loop)) begin
            pc_next = ROM_ADDR_W'(row.tgt);
        end else begin
            pc_next = pc + 1'b1;
            pc_wrap = &pc;
        end
    end

    useq_loop_cnt #(.W(LOOP_W)) u_loop_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .load     (advance && row.ldcnt),
        .load_val (LOOP_W'(row.cnt)),
        .dec      (advance && !row.eom && loop_taken && !row.ldcnt),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Nuke beats everything; eom leaves pc on the last row so the next trap simply reloads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= USEQ_IDLE;
            pc    <= ROM_ADDR_W'(USEQ_ROM_FIRST);
            nuops <= '0;
            err   <= 1'b0;
        end else if (nuke_rb1) begin
            state <= USEQ_IDLE;
        end else if (accept) begin
            state <= USEQ_FETCH;
            pc    <= trap_addr_de1;
            nuops <= '0;
        end else if (advance) begin
            nuops <= nuops + 1'b1;
            if (row.eom) begin
                state <= USEQ_IDLE;
            end else begin
                pc <= pc_next;
                if (pc_wrap || watchdog) begin
                    err <= 1'b1;
                end
                if (watchdog) begin
                    state <= USEQ_IDLE;
                end
            end
        end
    end

    // A loop row that also reloads the counter has no defined iteration count.
    assert property (@(posedge clk) disable iff (reset)
        !(uop_valid_uc0 && rom_loop_uc0 && rom_ldcnt_uc0));

endmodule

// File: tb/tb_useq_ctl.sv
// Self-checking bench for useq_ctl: directed flows plus a randomized run against a behavioural model.
module tb_useq_ctl;

    localparam int AW   = 8;
    localparam int LW   = 6;
    localparam int MAXU = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          nuke_rb1;
    logic          trap_valid_de1;
    logic [AW-1:0] trap_addr_de1;
    logic          trap_ready_uc0;
    logic          rename_ready_rn0;
    logic [AW-1:0] rom_addr_uc0;
    logic          rom_eom_uc0;
    logic          rom_jmp_uc0;
    logic          rom_loop_uc0;
    logic          rom_ldcnt_uc0;
    logic [AW-1:0] rom_tgt_uc0;
    logic [LW-1:0] rom_cnt_uc0;
    logic          uop_valid_uc0;
    logic          active_uc0;
    logic          err_uc0;

    logic          rom_eom   [256];
    logic          rom_jmp   [256];
    logic          rom_loop  [256];
    logic          rom_ldcnt [256];
    logic [AW-1:0] rom_tgt   [256];
    logic [LW-1:0] rom_cnt   [256];

    int checks = 0;
    int fails  = 0;

    bit m_busy;
    bit m_err;
    int m_pc;
    int m_cnt;
    int m_nuops;
    int m_accepts;
    int model_miss;
    logic [11:0] miss_obs;
    logic [11:0] miss_exp;
    int issued[$];

    useq_ctl #(.ROM_ADDR_W(AW), .LOOP_W(LW), .MAX_UOPS(MAXU)) dut (
        .clk              (clk),
        .reset            (reset),
        .nuke_rb1         (nuke_rb1),
        .trap_valid_de1   (trap_valid_de1),
        .trap_addr_de1    (trap_addr_de1),
        .trap_ready_uc0   (trap_ready_uc0),
        .rename_ready_rn0 (rename_ready_rn0),
        .rom_addr_uc0     (rom_addr_uc0),
        .rom_eom_uc0      (rom_eom_uc0),
        .rom_jmp_uc0      (rom_jmp_uc0),
        .rom_loop_uc0     (rom_loop_uc0),
        .rom_ldcnt_uc0    (rom_ldcnt_uc0),
        .rom_tgt_uc0      (rom_tgt_uc0),
        .rom_cnt_uc0      (rom_cnt_uc0),
        .uop_valid_uc0    (uop_valid_uc0),
        .active_uc0       (active_uc0),
        .err_uc0          (err_uc0)
    );

    always #5 clk = ~clk;

    // The bench plays the asynchronous ucode ROM.
    always_comb begin
        rom_eom_uc0   = rom_eom[rom_addr_uc0];
        rom_jmp_uc0   = rom_jmp[rom_addr_uc0];
        rom_loop_uc0  = rom_loop[rom_addr_uc0];
        rom_ldcnt_uc0 = rom_ldcnt[rom_addr_uc0];
        rom_tgt_uc0   = rom_tgt[rom_addr_uc0];
        rom_cnt_uc0   = rom_cnt[rom_addr_uc0];
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) begin
            rom_eom[i]   = 1'b0;
            rom_jmp[i]   = 1'b0;
            rom_loop[i]  = 1'b0;
            rom_ldcnt[i] = 1'b0;
            rom_tgt[i]   = '0;
            rom_cnt[i]   = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset            = 1'b1;
        nuke_rb1         = 1'b0;
        trap_valid_de1   = 1'b0;
        trap_addr_de1    = '0;
        rename_ready_rn0 = 1'b0;
        @(negedge clk);
        m_busy  = 1'b0;
        m_err   = 1'b0;
        m_pc    = 0;
        m_cnt   = 0;
        m_nuops = 0;
    endtask

    // One cycle: drive inputs, sample outputs, score them against the flow model, then step the model.
    task automatic applyStimulus(input bit nuke, input bit tv, input int ta, input bit rr,
                                 output logic [11:0] obs);
        bit   exp_ready;
        bit   exp_valid;
        logic [11:0] expv;
        bit   r_eom;
        bit   r_jmp;
        bit   r_loop;
        bit   r_ld;
        int   r_tgt;
        int   r_cnt;
        int   nxt_cnt;
        @(negedge clk);
        reset            = 1'b0;
        nuke_rb1         = nuke;
        trap_valid_de1   = tv;
        trap_addr_de1    = AW'(ta);
        rename_ready_rn0 = rr;
        #1;
        obs       = {trap_ready_uc0, uop_valid_uc0, active_uc0, err_uc0, rom_addr_uc0};
        exp_ready = !m_busy && rr && !nuke;
        exp_valid = m_busy && !nuke;
        expv      = {exp_ready, exp_valid, exp_valid, m_err, AW'(m_pc)};
        if (obs !== expv) begin
            if (model_miss == 0) begin
                miss_obs = obs;
                miss_exp = expv;
            end
            model_miss++;
        end
        if (obs[10] && rr) issued.push_back(int'(obs[7:0]));

        if (nuke) begin
            m_busy = 1'b0;
        end else if (tv && exp_ready) begin
            m_pc    = ta % 256;
            m_cnt   = 0;
            m_nuops = 0;
            m_busy  = 1'b1;
            m_accepts++;
        end else if (exp_valid && rr) begin
            r_eom   = rom_eom[m_pc];
            r_jmp   = rom_jmp[m_pc];
            r_loop  = rom_loop[m_pc];
            r_ld    = rom_ldcnt[m_pc];
            r_tgt   = int'(rom_tgt[m_pc]);
            r_cnt   = int'(rom_cnt[m_pc]);
            nxt_cnt = m_cnt;
            m_nuops++;
            if (r_eom) begin
                m_busy = 1'b0;
            end else begin
                if (r_loop && m_cnt != 0) begin
                    m_pc    = r_tgt;
                    nxt_cnt = m_cnt - 1;
                end else if (r_jmp && !r_loop) begin
                    m_pc = r_tgt;
                end else begin
                    if (m_pc == 255) m_err = 1'b1;
                    m_pc = (m_pc + 1) % 256;
                end
                if (m_nuops == MAXU) begin
                    m_err  = 1'b1;
                    m_busy = 1'b0;
                end
            end
            if (r_ld) nxt_cnt = r_cnt;
            m_cnt = nxt_cnt;
        end
    endtask

    // Trap into addr with rename always ready and run until the flow goes idle or the budget expires.
    task automatic run_flow(input int addr, input int budget, output bit finished, output logic [11:0] last);
        logic [11:0] obs;
        finished = 1'b0;
        applyStimulus(1'b0, 1'b1, addr, 1'b1, obs);
        last = obs;
        for (int i = 0; i < budget; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
            last = obs;
            if (!obs[9]) begin
                finished = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        do_reset();
        #1;
        checks++;
        if ({trap_ready_uc0, uop_valid_uc0, active_uc0, err_uc0, rom_addr_uc0} !== 12'h000) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h want 000",
                     {trap_ready_uc0, uop_valid_uc0, active_uc0, err_uc0, rom_addr_uc0});
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        checks++;
        if (obs[11] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready: got %b want 1", obs[11]);
        end
    endtask

    task automatic test_sequential();
        bit fin;
        logic [11:0] last;
        clear_rom();
        rom_eom[8'h12] = 1'b1;
        issued.delete();
        model_miss = 0;
        run_flow(8'h10, 20, fin, last);
        checks++;
        if (!fin || issued.size() != 3 || issued[0] != 'h10 || issued[1] != 'h11 || issued[2] != 'h12) begin
            fails++;
            $display("[TB] FAIL seq_flow: got %0d uops first=%h,%h,%h done=%b want 3 uops 10,11,12 done=1",
                     issued.size(), issued[0], issued[1], issued[2], fin);
        end
        checks++;
        if (model_miss != 0) begin
            fails++;
            $display("[TB] FAIL seq_model: got %h want %h (%0d cycles differ)", miss_obs, miss_exp, model_miss);
        end
    endtask

    task automatic test_loop();
        bit fin;
        logic [11:0] last;
        int n21;
        clear_rom();
        rom_ldcnt[8'h20] = 1'b1;
        rom_cnt[8'h20]   = 6'd3;
        rom_loop[8'h21]  = 1'b1;
        rom_tgt[8'h21]   = 8'h21;
        rom_eom[8'h22]   = 1'b1;
        issued.delete();
        model_miss = 0;
        run_flow(8'h20, 30, fin, last);
        n21 = 0;
        foreach (issued[i]) if (issued[i] == 'h21) n21++;
        checks++;
        if (!fin || n21 != 4 || issued.size() != 6 || issued[issued.size()-1] != 'h22) begin
            fails++;
            $display("[TB] FAIL loop_flow: got %0d issues of 21, %0d uops, last %h want 4, 6, 22",
                     n21, issued.size(), issued[issued.size()-1]);
        end
        checks++;
        if (model_miss != 0) begin
            fails++;
            $display("[TB] FAIL loop_model: got %h want %h (%0d cycles differ)", miss_obs, miss_exp, model_miss);
        end
    endtask

    task automatic test_stall();
        logic [11:0] obs;
        bit fin;
        clear_rom();
        rom_eom[8'h33] = 1'b1;
        issued.delete();
        model_miss = 0;
        applyStimulus(1'b0, 1'b1, 8'h30, 1'b1, obs);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b0, obs);
            checks++;
            if (obs[10:0] !== 11'h631) begin
                fails++;
                $display("[TB] FAIL stall_hold: got %h want 631", obs[10:0]);
            end
        end
        fin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
            if (!obs[9]) begin
                fin = 1'b1;
                break;
            end
        end
        checks++;
        if (!fin || issued.size() != 4 || issued[1] != 'h31 || issued[2] != 'h32) begin
            fails++;
            $display("[TB] FAIL stall_flow: got %0d uops done=%b want 4 uops done=1", issued.size(), fin);
        end
        checks++;
        if (model_miss != 0) begin
            fails++;
            $display("[TB] FAIL stall_model: got %h want %h (%0d cycles differ)", miss_obs, miss_exp, model_miss);
        end
    endtask

    task automatic test_nuke();
        logic [11:0] obs;
        clear_rom();
        rom_eom[8'h57] = 1'b1;
        model_miss = 0;
        applyStimulus(1'b0, 1'b1, 8'h50, 1'b1, obs);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        applyStimulus(1'b1, 1'b1, 8'h70, 1'b1, obs);
        checks++;
        if (obs[11:9] !== 3'b000) begin
            fails++;
            $display("[TB] FAIL nuke_suppress: got ready/valid/active %b want 000", obs[11:9]);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        checks++;
        if (obs[11:9] !== 3'b100) begin
            fails++;
            $display("[TB] FAIL nuke_idle: got ready/valid/active %b want 100", obs[11:9]);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        checks++;
        if (obs[10:9] !== 2'b00) begin
            fails++;
            $display("[TB] FAIL nuke_no_accept: got valid/active %b want 00", obs[10:9]);
        end
        checks++;
        if (model_miss != 0) begin
            fails++;
            $display("[TB] FAIL nuke_model: got %h want %h (%0d cycles differ)", miss_obs, miss_exp, model_miss);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] obs;
        clear_rom();
        rom_eom[8'h60] = 1'b1;
        model_miss = 0;
        applyStimulus(1'b0, 1'b1, 8'h60, 1'b1, obs);
        applyStimulus(1'b0, 1'b1, 8'h60, 1'b1, obs);
        checks++;
        if (obs[10:0] !== 11'h660) begin
            fails++;
            $display("[TB] FAIL b2b_first: got %h want 660", obs[10:0]);
        end
        applyStimulus(1'b0, 1'b1, 8'h60, 1'b1, obs);
        checks++;
        if (obs[11:10] !== 2'b10) begin
            fails++;
            $display("[TB] FAIL b2b_gap: got ready/valid %b want 10", obs[11:10]);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        checks++;
        if (obs[10:0] !== 11'h660) begin
            fails++;
            $display("[TB] FAIL b2b_second: got %h want 660", obs[10:0]);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        checks++;
        if (model_miss != 0) begin
            fails++;
            $display("[TB] FAIL b2b_model: got %h want %h (%0d cycles differ)", miss_obs, miss_exp, model_miss);
        end
    endtask

    task automatic test_watchdog();
        logic [11:0] obs;
        logic [11:0] last;
        bit fin;
        clear_rom();
        rom_jmp[8'h40] = 1'b1;
        rom_tgt[8'h40] = 8'h40;
        issued.delete();
        model_miss = 0;
        run_flow(8'h40, 100, fin, last);
        checks++;
        if (!fin || issued.size() != MAXU || last[9:8] !== 2'b01) begin
            fails++;
            $display("[TB] FAIL watchdog_trip: got %0d uops active/err %b done=%b want %0d uops 01 done=1",
                     issued.size(), last[9:8], fin, MAXU);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        checks++;
        if (obs[8] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL watchdog_sticky: got err %b want 1", obs[8]);
        end
        checks++;
        if (model_miss != 0) begin
            fails++;
            $display("[TB] FAIL watchdog_model: got %h want %h (%0d cycles differ)", miss_obs, miss_exp, model_miss);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] obs;
        do_reset();
        clear_rom();
        rom_eom[8'h00] = 1'b1;
        model_miss = 0;
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, obs);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        checks++;
        if (obs[10:0] !== 11'h700) begin
            fails++;
            $display("[TB] FAIL wrap_pc: got valid/active/err/addr %h want 700", obs[10:0]);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b1, obs);
        do_reset();
        #1;
        checks++;
        if ({active_uc0, err_uc0} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL wrap_reset: got active/err %b want 00", {active_uc0, err_uc0});
        end
        checks++;
        if (model_miss != 0) begin
            fails++;
            $display("[TB] FAIL wrap_model: got %h want %h (%0d cycles differ)", miss_obs, miss_exp, model_miss);
        end
    endtask

    task automatic test_random();
        logic [11:0] obs;
        do_reset();
        clear_rom();
        for (int i = 0; i < 256; i++) begin
            rom_eom[i]   = ($urandom_range(0, 3) == 0);
            rom_jmp[i]   = ($urandom_range(0, 5) == 0);
            rom_loop[i]  = ($urandom_range(0, 5) == 0);
            rom_ldcnt[i] = !rom_loop[i] && ($urandom_range(0, 3) == 0);
            rom_tgt[i]   = AW'($urandom_range(0, 255));
            rom_cnt[i]   = LW'($urandom_range(0, 7));
        end
        model_miss = 0;
        m_accepts  = 0;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, obs);
        end
        checks++;
        if (m_accepts < 20) begin
            fails++;
            $display("[TB] FAIL random_accepts: got %0d flows want at least 20", m_accepts);
        end
        checks++;
        if (model_miss != 0) begin
            fails++;
            $display("[TB] FAIL random_model: got %h want %h (%0d cycles differ)", miss_obs, miss_exp, model_miss);
        end
    endtask

    initial begin
        reset            = 1'b1;
        nuke_rb1         = 1'b0;
        trap_valid_de1   = 1'b0;
        trap_addr_de1    = '0;
        rename_ready_rn0 = 1'b0;
        model_miss       = 0;
        m_accepts        = 0;
        miss_obs         = '0;
        miss_exp         = '0;
        clear_rom();
        test_reset();
        test_sequential();
        test_loop();
        test_stall();
        test_nuke();
        test_back_to_back();
        test_watchdog();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
